serial_tx8b: RTL and testbench



---
 rtl/serial_tx8b.sv | 164 ++++++++++++++++
 tb/tb_serial_tx8b.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx8b.sv
// serial_tx8b: parallel-to-serial frame transmitter, MSB first.
// Takes bytes over a valid/ready handshake into a one-deep holding register,
// shifts each out one bit per clock and inserts GAP_CYC idle cycles between frames.
// Optional build macro SERTX_PARITY_EN appends an even-parity bit to each frame.
module serial_tx8b #(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              sdout,
  output logic              sframe,
  output logic              busy,
  output logic              done
);

`ifdef SERTX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LD = CW'(FRAME_LEN - 1);
  localparam logic [3:0]    GAP_LD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} st_t;

  st_t               st, st_nx;
  logic [DATA_W-1:0] hold, hold_nx;
  logic              hold_full, hold_full_nx;
  // Only the bits still to be sent live here; the bit on the wire is sdout itself.
  logic [DATA_W-2:0] sh, sh_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [3:0]        gcnt, gcnt_nx;
  logic              sdout_nx, sframe_nx, done_nx;
  logic              load, last, accept;
`ifdef SERTX_PARITY_EN
  logic              par, par_nx;
`endif

  assign accept    = din_valid & din_ready;
  assign din_ready = ~hold_full & ~rst;
  assign busy      = (st != IDLE) | hold_full;
  // cnt reaches zero while the final frame bit is on the wire
  assign last      = (cnt == '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      sdout     <= 1'b0;
      sframe    <= 1'b0;
      done      <= 1'b0;
`ifdef SERTX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      st        <= st_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      sh        <= sh_nx;
      cnt       <= cnt_nx;
      gcnt      <= gcnt_nx;
      sdout     <= sdout_nx;
      sframe    <= sframe_nx;
      done      <= done_nx;
`ifdef SERTX_PARITY_EN
      par       <= par_nx;
`endif
    end
  end

  // Next-state: a held byte is loaded from IDLE, at the end of the gap, or
  // straight after the last bit when there is no gap
  always_comb begin
    st_nx = st;
    load  = 1'b0;
    unique case (st)
      IDLE: begin
        if (hold_full) begin
          st_nx = SHIFT;
          load  = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          if (GAP_CYC > 0) begin
            st_nx = GAP;
          end else if (hold_full) begin
            st_nx = SHIFT;
            load  = 1'b1;
          end else begin
            st_nx = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt == 4'd0) begin
          if (hold_full) begin
            st_nx = SHIFT;
            load  = 1'b1;
          end else begin
            st_nx = IDLE;
          end
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // Outputs and datapath: compute next values of the registered outputs
  always_comb begin
    hold_nx      = accept ? din : hold;
    hold_full_nx = hold_full;
    sh_nx        = sh;
    cnt_nx       = cnt;
    gcnt_nx      = gcnt;
    sdout_nx     = 1'b0;
    sframe_nx    = 1'b0;
    done_nx      = 1'b0;
`ifdef SERTX_PARITY_EN
    par_nx       = par;
`endif

    // ready is low while full, so accept and load never meet on one edge
    if (accept)    hold_full_nx = 1'b1;
    else if (load) hold_full_nx = 1'b0;

    if (load) begin
      sh_nx     = hold[DATA_W-2:0];
      cnt_nx    = CNT_LD;
      sdout_nx  = hold[DATA_W-1];
      sframe_nx = 1'b1;
`ifdef SERTX_PARITY_EN
      par_nx    = ^hold;
`endif
    end else if (st == SHIFT && !last) begin
      sh_nx     = sh << 1;
      cnt_nx    = cnt - CW'(1);
      sdout_nx  = sh[DATA_W-2];
      sframe_nx = 1'b1;
`ifdef SERTX_PARITY_EN
      // final SHIFT cycle carries the parity bit instead of data
      if (cnt == CW'(1)) sdout_nx = par;
`endif
    end

    if (st == SHIFT && last) begin
      done_nx = 1'b1;
      gcnt_nx = GAP_LD;
    end else if (st == GAP && gcnt != 4'd0) begin
      gcnt_nx = gcnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_serial_tx8b.sv
// Bench for serial_tx8b: two instances (GAP_CYC=2 and GAP_CYC=0) share clk/rst.
// A timeline model predicts every output cycle from the accept edges; directed
// tests add literal expectations on captured bit streams and strobe timing.
module tb_serial_tx8b;
  localparam int DW = 8;
`ifdef SERTX_PARITY_EN
  localparam int F = DW + 1;
`else
  localparam int F = DW;
`endif
  localparam int DEPTH = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dv  = '0;
  logic [7:0] dd [2];
  wire  [1:0] rdy, sd, fr, bz, dn;

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int gap [2] = '{2, 0};

  bit e_sd [2][DEPTH];
  bit e_fr [2][DEPTH];
  bit e_dn [2][DEPTH];
  bit e_bz [2][DEPTH];
  int nfree [2];
  int pend  [2];

  logic [63:0] acc0, acc1;
  int fe0[$], de0[$], fe1[$], de1[$];

  always #5 clk = ~clk;

  serial_tx8b #(.DATA_W(DW), .GAP_CYC(2)) u_g2 (
    .clk(clk), .rst(rst), .din_valid(dv[0]), .din(dd[0]), .din_ready(rdy[0]),
    .sdout(sd[0]), .sframe(fr[0]), .busy(bz[0]), .done(dn[0]));

  serial_tx8b #(.DATA_W(DW), .GAP_CYC(0)) u_g0 (
    .clk(clk), .rst(rst), .din_valid(dv[1]), .din(dd[1]), .din_ready(rdy[1]),
    .sdout(sd[1]), .sframe(fr[1]), .busy(bz[1]), .done(dn[1]));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // frame bits as they should appear on sdout, MSB first
  function automatic logic [63:0] pb(input logic [7:0] b);
`ifdef SERTX_PARITY_EN
    return {55'd0, b, ^b};
`else
    return {56'd0, b};
`endif
  endfunction

  // Timeline model: a byte accepted at edge A starts at max(A+1, end of previous frame + gap)
  initial begin
    for (int k = 0; k < 2; k++) begin nfree[k] = 0; pend[k] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          for (int i = cyc; i < DEPTH; i++) begin
            e_sd[k][i] = 0; e_fr[k][i] = 0; e_dn[k][i] = 0; e_bz[k][i] = 0;
          end
          nfree[k] = 0;
          pend[k]  = cyc;
        end else if (dv[k] && (cyc - 1) >= pend[k]) begin
          int l;
          l = (cyc + 1 > nfree[k]) ? cyc + 1 : nfree[k];
          for (int j = 0; j < DW; j++) begin
            if (l + j < DEPTH) begin e_sd[k][l+j] = dd[k][DW-1-j]; e_fr[k][l+j] = 1; end
          end
`ifdef SERTX_PARITY_EN
          if (l + DW < DEPTH) begin e_sd[k][l+DW] = ^dd[k]; e_fr[k][l+DW] = 1; end
`endif
          if (l + F < DEPTH) e_dn[k][l+F] = 1;
          for (int i = cyc; i < l + F + gap[k]; i++) if (i < DEPTH) e_bz[k][i] = 1;
          nfree[k] = l + F + gap[k];
          pend[k]  = l;
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (cyc >= 1 && cyc < DEPTH) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.sdout", k),     sd[k],  e_sd[k][cyc]);
        chk($sformatf("u%0d.sframe", k),    fr[k],  e_fr[k][cyc]);
        chk($sformatf("u%0d.done", k),      dn[k],  e_dn[k][cyc]);
        chk($sformatf("u%0d.busy", k),      bz[k],  e_bz[k][cyc]);
        chk($sformatf("u%0d.din_ready", k), rdy[k], (rst === 1'b0) && (cyc >= pend[k]));
      end
    end
  end

  // Capture serial stream and strobe edges for the directed checks
  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      if (fr[0] === 1'b1) begin acc0 = {acc0[62:0], sd[0]}; fe0.push_back(cyc); end
      if (dn[0] === 1'b1) de0.push_back(cyc);
      if (fr[1] === 1'b1) begin acc1 = {acc1[62:0], sd[1]}; fe1.push_back(cyc); end
      if (dn[1] === 1'b1) de1.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr();
    acc0 = '0; acc1 = '0;
    fe0.delete(); de0.delete(); fe1.delete(); de1.delete();
  endtask

  task automatic send(input int k, input logic [7:0] b, output int e);
    int g;
    g = 0;
    @(posedge clk); #1;
    dv[k] = 1'b1; dd[k] = b;
    forever begin
      @(negedge clk);
      if (rdy[k] === 1'b1) break;
      g++;
      if (g > 200) begin
        chk("send_timeout", 0, 1);
        dv[k] = 1'b0; e = cyc;
        return;
      end
    end
    @(posedge clk); #1;
    e = cyc;
    dv[k] = 1'b0;
  endtask

  task automatic wait_edge(input int e);
    int g;
    g = 0;
    while (cyc < e && g < 1000) begin @(posedge clk); #1; g++; end
    if (cyc != e) chk("wait_edge", cyc, e);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k);
    int g;
    g = 0;
    @(negedge clk);
    while (bz[k] !== 1'b0 && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n, a, b, c;
    dd[0] = '0; dd[1] = '0;
    acc0 = '0; acc1 = '0;

    // reset behaviour
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_ready_low", rdy[0], 0);
    chk("rst_sdout", sd[0], 0);
    chk("rst_busy", bz[0], 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy[0], 1);
    chk("idle_done", dn[0], 0);

    // single byte, gap 2
    clr();
    send(0, 8'hA5, n);
    wait_edge(n + F + 2);
    chk("t1_busy_in_gap", bz[0], 1);
    wait_edge(n + F + 3);
    chk("t1_idle", bz[0], 0);
    wait_edge(n + F + 4);
    chk("t1_bits", acc0, pb(8'hA5));
    chk("t1_nbits", fe0.size(), F);
    chk("t1_first_bit", fe0[0], n + 1);
    chk("t1_ndone", de0.size(), 1);
    chk("t1_done_edge", de0[0], n + F + 1);

    // back-to-back, second offered while first shifts
    clr();
    send(0, 8'h3C, a);
    send(0, 8'hFF, b);
    @(negedge clk);
    chk("t2_ready_low", rdy[0], 0);
    wait_idle(0);
    chk("t2_bits", acc0, (pb(8'h3C) << F) | pb(8'hFF));
    chk("t2_gap", fe0[F] - fe0[F-1], 3);
    chk("t2_ndone", de0.size(), 2);

    // backpressure: three bytes each held until accepted
    clr();
    send(0, 8'h11, a);
    send(0, 8'h22, b);
    send(0, 8'h33, c);
    wait_idle(0);
    chk("t3_bits", acc0, (((pb(8'h11) << F) | pb(8'h22)) << F) | pb(8'h33));
    chk("t3_nbits", fe0.size(), 3 * F);
    chk("t3_ndone", de0.size(), 3);

    // gap 0 stream
    clr();
    send(1, 8'h80, a);
    send(1, 8'h01, b);
    wait_idle(1);
    chk("t4_bits", acc1, (pb(8'h80) << F) | pb(8'h01));
    chk("t4_nbits", fe1.size(), 2 * F);
    chk("t4_first", fe1[0], a + 1);
    chk("t4_contig", fe1[2*F-1] - fe1[0], 2 * F - 1);
    chk("t4_done1", de1[0], fe1[F-1] + 1);
    chk("t4_done2", de1[1], fe1[2*F-1] + 1);

    // reset after third bit of 0xF0
    clr();
    send(0, 8'hF0, n);
    wait_edge(n + 2);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t5_nbits", fe0.size(), 3);
    chk("t5_bits", acc0, 64'h7);
    chk("t5_sdout", sd[0], 0);
    chk("t5_sframe", fr[0], 0);
    chk("t5_done", dn[0], 0);
    chk("t5_ready", rdy[0], 1);
    clr();
    send(0, 8'h55, n);
    wait_idle(0);
    chk("t5_bits_after", acc0, pb(8'h55));
    chk("t5_ndone", de0.size(), 1);
    chk("t5_done_edge", de0[0], n + F + 1);

`ifdef SERTX_PARITY_EN
    // parity frames
    clr();
    send(0, 8'h07, n);
    wait_idle(0);
    chk("t6_par1", acc0, 64'h00F);
    chk("t6_done_edge", de0[0], n + 10);
    clr();
    send(0, 8'h03, n);
    wait_idle(0);
    chk("t6_par0", acc0, 64'h006);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
